// File: rtl/config_chain_driver.sv
// Source end of the 16-bit RAM configuration chain: buffers host words in a
// small FIFO and emits exactly total_words of them, one per cycle, per start.
module config_chain_driver #(
  parameter int LOG_DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] total_words,
  input  logic [15:0] host_data,
  input  logic        host_valid,
  output logic        host_ready,
  output logic [15:0] config_out,
  output logic        config_out_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_sent
);

  localparam int PTR_W = LOG_DEPTH;
  localparam int CNT_W = LOG_DEPTH + 1;
  localparam int DEPTH = 1 << LOG_DEPTH;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [15:0]      WORD_ONE = 16'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [15:0]      words_sent_q, words_sent_d;
  logic [15:0]      config_out_q, config_out_d;
  logic             config_out_valid_q, config_out_valid_d;

  logic push;
  logic pop;
  logic start_accept;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot to a full FIFO.
  assign host_ready   = (count_q != CNT_FULL);
  assign push         = host_valid & host_ready;
  assign pop          = (state_q == ST_SEND) && (count_q != '0);
  assign start_accept = start && (state_q != ST_SEND);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_ptr_d           = rd_ptr_q;
    wr_ptr_d           = wr_ptr_q;
    count_d            = count_q;
    state_d            = state_q;
    remaining_d        = remaining_q;
    words_sent_d       = words_sent_q;
    config_out_d       = config_out_q;
    config_out_valid_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d           = rd_ptr_q + PTR_ONE;
      config_out_d       = mem_q[rd_ptr_q];
      config_out_valid_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_SEND: begin
        if (pop) begin
          remaining_d  = remaining_q - WORD_ONE;
          words_sent_d = words_sent_q + WORD_ONE;
          if (remaining_q == WORD_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        // DONE re-arms exactly like IDLE; a zero count goes straight to DONE.
        if (start_accept) begin
          words_sent_d = '0;
          remaining_d  = total_words;
          state_d      = (total_words == '0) ? ST_DONE : ST_SEND;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      state_q            <= ST_IDLE;
      remaining_q        <= '0;
      words_sent_q       <= '0;
      config_out_q       <= '0;
      config_out_valid_q <= 1'b0;
    end else begin
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
      count_q            <= count_d;
      state_q            <= state_d;
      remaining_q        <= remaining_d;
      words_sent_q       <= words_sent_d;
      config_out_q       <= config_out_d;
      config_out_valid_q <= config_out_valid_d;
    end
  end

  // NOTE: the storage array is not reset; reset empties the FIFO through the
  // pointers and count, so stale entries can never be read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_data;
    end
  end

  assign config_out       = config_out_q;
  assign config_out_valid = config_out_valid_q;
  assign busy             = (state_q == ST_SEND);
  assign done             = (state_q == ST_DONE);
  assign words_sent       = words_sent_q;

endmodule

// File: doc/config_chain_driver.md
# config_chain_driver

Source end of the 16-bit RAM configuration chain. Accepts configuration words from a host-side valid/ready stream, buffers them in a small FIFO, and emits exactly a programmed number of words onto the chain, one word per cycle when data is available. Its `config_out`/`config_out_valid` feed the `ram_config_in`/`ram_config_in_valid` of the first lookup table in the chain; downstream tables self-load in order.

## Interface
- `LOG_DEPTH`, 3: log2 of FIFO depth; depth is 8 words.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; arms a transfer of `total_words` words.
- `total_words`  in  16  word count for the transfer; sampled only when `start` is accepted.
- `host_data`  in  16  configuration word from the host.
- `host_valid`  in  1  `host_data` is valid.
- `host_ready`  out  1  FIFO can accept a word this cycle.
- `config_out`  out  16  chain data, registered.
- `config_out_valid`  out  1  `config_out` is valid this cycle, registered.
- `busy`  out  1  high in SEND.
- `done`  out  1  high in DONE.
- `words_sent`  out  16  words emitted since the last accepted `start`.

## Operation
- FIFO: 2^LOG_DEPTH entries, with read pointer, write pointer, and an occupancy count of LOG_DEPTH+1 bits. Pointers wrap modulo depth.
- `host_ready` = (count != depth). It is derived from the registered count only. A pop in the same cycle does not open a slot to a full FIFO.
- Push occurs when `host_valid & host_ready`. Pushes are accepted in every state, so the host may preload before `start`.
- FSM states: IDLE, SEND, DONE.
- IDLE -> SEND on `start` when `total_words` != 0. This latches `remaining` = `total_words` and clears `words_sent`.
- IDLE -> DONE on `start` when `total_words` == 0. This clears `words_sent`.
- SEND pops one word per cycle when count != 0; there is no pop when the FIFO is empty. Each pop decrements `remaining` and increments `words_sent`.
- The pop that brings `remaining` from 1 to 0 moves the FSM SEND -> DONE.
- DONE: no pops. A `start` in DONE behaves as a `start` in IDLE.
- `start` in SEND is ignored.
- Output register: `config_out` is loaded with the popped word. `config_out_valid` = 1 in the cycle after a pop and 0 otherwise. `config_out` holds its last value when not valid.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO is not poppable until the next cycle; there is no bypass.
- Words left in the FIFO after DONE remain for the next transfer. Only `reset` flushes the FIFO.

## Timing
- Reset values:
  - `host_ready`=1, `config_out`=0, `config_out_valid`=0, `busy`=0, `done`=0, `words_sent`=0.
  - FIFO empty, pointers 0, state IDLE.
- Reset asserted mid-transfer: on the next edge the block returns to full reset state and the FIFO contents are discarded.
- Start latency: `start` at edge N. Earliest pop at edge N+1. First `config_out_valid` in cycle N+2.
- Steady state with FIFO non-empty: one word per cycle, back to back, with no bubbles.
- Push-to-output latency with an empty FIFO while in SEND: push at edge N, pop at N+1, valid at N+2.
- `done` rises on the edge of the final pop. The final word's `config_out_valid` is in the same cycle `done` is first high.
- `words_sent` equals the number of pops and is visible the cycle after each pop. The total number of valid output beats equals `total_words` exactly.
- `busy` and `done` are never high together.

## Test plan
- Preload 5 words 0x0011..0x0015 in IDLE, then `start` with `total_words`=5. Required: valid in 5 consecutive cycles starting 2 cycles after `start`, data in order, `done`=1 with the last beat, `words_sent`=5.
- Push 10 words with `host_valid` held high and no `start`. Required: exactly 8 accepted, `host_ready`=0 after the 8th, and the host stalls with no data loss. Then `start` with `total_words`=10 and keep pushing. Required: 10 beats in order.
- `start` with `total_words`=3 and the FIFO empty; push 1 word every 4 cycles. Required: each beat 2 cycles after its push, no spurious valid, DONE after the 3rd.
- `start` with `total_words`=0. Required: `done`=1 the next cycle, no valid beats, FIFO untouched.
- Pulse `start` again mid-SEND with a different count. Required: ignored and the original count completes.
- Assert `reset` after 2 of 6 beats with 4 words queued. Required: all outputs return to reset values, `host_ready`=1, and no further beats without a new `start`.
